// File: rtl/inst_queue_pkg.sv
// Shared constants for the fetch/decode instruction buffer.
package inst_queue_pkg;

    localparam logic        RstEnable      = 1'b1;
    localparam logic        Stop           = 1'b1;
    localparam logic        NoStop         = 1'b0;
    localparam logic        Valid          = 1'b1;
    localparam logic        InValid        = 1'b0;
    localparam int unsigned InstAddrBus    = 32;
    localparam int unsigned InstBus        = 32;
    localparam int unsigned RegBus         = 32;
    localparam logic [31:0] ZeroWord       = 32'h0;
    localparam int unsigned InstQueueDepth = 4;
    // Bit of the CTRL stall vector that freezes the ID stage.
    localparam int unsigned StallIdBit     = 2;

endpackage

// File: rtl/inst_queue_sync_fifo.sv
// Single-clock FIFO with occupancy counter; the counter is the only
// source of full/empty, the pointers simply wrap.
module sync_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear drops every entry.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_queue.sv
// IF/ID instruction buffer: FIFO of {pc, inst, excepttype} with an
// empty-queue bypass into the registered ID outputs.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = InstQueueDepth,
    parameter int unsigned ADDR_W    = InstAddrBus,
    parameter int unsigned INST_W    = InstBus,
    parameter int unsigned EXC_W     = RegBus,
    parameter int unsigned AF_MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [5:0]               stall,
    input  logic                     inst_valid,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [INST_W-1:0]        if_inst,
    input  logic [EXC_W-1:0]         pc_excepttype,
    input  logic                     branch_flag,
    input  logic                     pc_ready,
    output logic                     inst_ready,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [INST_W-1:0]        id_inst,
    output logic [EXC_W-1:0]         id_excepttype,
    output logic                     stallreq_for_if,
    output logic                     stallreq_for_ex
);

    localparam int unsigned WIDTH = ADDR_W + INST_W + EXC_W;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             enq;
    logic             adv;
    logic             bypass;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic             unused_stall;

    assign unused_stall = ^{stall[5:StallIdBit+1], stall[StallIdBit-1:0]};

    assign inst_ready  = ~full;
    assign almost_full = (count >= CNT_W'(DEPTH - AF_MARGIN));

    assign enq    = inst_valid & inst_ready & ~flush;
    assign adv    = (stall[StallIdBit] == NoStop) & ~flush;
    assign pop    = adv & ~empty;
    assign bypass = adv & empty & enq;
    assign push   = enq & ~bypass;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({if_pc, if_inst, pc_excepttype}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // ID output register: queue head first, then bypass, else bubble; held while ID stalls.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            id_pc         <= '0;
            id_inst       <= '0;
            id_excepttype <= '0;
        end else if (adv) begin
            if (!empty) begin
                {id_pc, id_inst, id_excepttype} <= head;
            end else if (enq) begin
                id_pc         <= if_pc;
                id_inst       <= if_inst;
                id_excepttype <= pc_excepttype;
            end else begin
                id_pc         <= '0;
                id_inst       <= '0;
                id_excepttype <= '0;
            end
        end
    end

    // Stall requests are combinational so CTRL reacts in the same cycle.
    always_comb begin
        stallreq_for_if = (rst != RstEnable) & empty & ~inst_valid;
        stallreq_for_ex = (rst != RstEnable) & branch_flag & ~pc_ready;
    end

endmodule
